vga_write_arbiter: RTL and testbench

Shares the single VGA framebuffer write port between the sprite engines (player, obstacle manager, score/HUD overlay). Each requester asks for a burst, receives an exclusive grant, streams pixels, and releases. Round-robin arbitration, off-screen clipping, and a hold watchdog keep a stuck engine from freezing the display. Sits between all drawing blocks and the VGA adapter's write port.

---
 rtl/lane_runner_pkg.sv | 36 +++
 rtl/rr_picker.sv | 35 +++
 rtl/vga_write_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_runner_pkg.sv
// Shared constants and types for the lane-runner drawing pipeline.
// Holds the screen geometry, the pixel format, the lane layout and the
// framebuffer write arbiter state type. There are no ports; modules
// import it with import lane_runner_pkg::*.
package lane_runner_pkg;

  // Pixel and coordinate formats.
  localparam int unsigned nX          = 10;
  localparam int unsigned nY          = 9;
  localparam int unsigned COLOR_DEPTH = 9;

  // Visible area. Anything at or beyond these limits is off-screen.
  localparam logic [nX-1:0] XSCREEN = 10'd640;
  localparam logic [nY-1:0] YSCREEN = 9'd480;

  // Colour the sprite engines treat as see-through. They drop such pixels
  // themselves, so the arbiter never looks at it.
  localparam logic [COLOR_DEPTH-1:0] TRANSPARENT_COLOR = 9'h1C7;

  // Lane layout of the playfield.
  localparam int unsigned NUM_LANES  = 3;
  localparam int unsigned LANE_WIDTH = 160;
  localparam int unsigned LANE_X0    = 80;

  // Framebuffer write arbiter states.
  typedef enum logic {
    StIdle,
    StGrant
  } arb_state_e;

  // True when the coordinate lies inside the visible area.
  function automatic logic on_screen(input logic [nX-1:0] x, input logic [nY-1:0] y);
    return (x < XSCREEN) && (y < YSCREEN);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Scans the eligible vector starting one position after the last winner,
// wrapping around, and reports the first eligible requester.
//   eligible_i : requesters that may be granted this cycle
//   last_i     : index of the previous winner
//   winner_o   : one-hot winner (all zero when nothing is eligible)
//   valid_o    : a winner was found
module rr_picker #(
  parameter int unsigned NumReq = 3,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] eligible_i,
  input  logic [IdxW-1:0]   last_i,
  output logic [NumReq-1:0] winner_o,
  output logic              valid_o
);

  always_comb begin
    logic            found;
    logic [IdxW-1:0] idx;
    found    = 1'b0;
    idx      = '0;
    winner_o = '0;
    // Offset NumReq wraps back to last_i itself, so it is considered last.
    for (int unsigned off = 1; off <= NumReq; off++) begin
      idx = IdxW'((32'(last_i) + off) % NumReq);
      if (!found && eligible_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Framebuffer write-port arbiter for the sprite engines.
// Requesters (0 = player, 1 = obstacles, 2 = HUD) raise req for a burst, get
// an exclusive registered grant, stream pixels with wr and drop req to
// release. Grants rotate round-robin. A grant held for MAX_HOLD cycles is
// forcibly released and the offender masked until it drops req. Pixels
// falling off-screen are discarded without disturbing the last written pixel.
//   Clock, Resetn   : clock, synchronous active-low reset
//   req, wr         : per-requester burst request and pixel valid
//   x_in/y_in/color_in : packed per-requester pixel, requester k at [k*W +: W]
//   gnt             : registered one-hot grant
//   VGA_x/y/color/write : registered pixel to the VGA adapter
//   timeout         : one-cycle pulse when a grant is forcibly released
module vga_write_arbiter
  import lane_runner_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned MAX_HOLD = 8192
) (
  input  logic                           Clock,
  input  logic                           Resetn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             wr,
  input  logic [NUM_REQ*nX-1:0]          x_in,
  input  logic [NUM_REQ*nY-1:0]          y_in,
  input  logic [NUM_REQ*COLOR_DEPTH-1:0] color_in,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [nX-1:0]                  VGA_x,
  output logic [nY-1:0]                  VGA_y,
  output logic [COLOR_DEPTH-1:0]         VGA_color,
  output logic                           VGA_write,
  output logic                           timeout
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(MAX_HOLD - 1);
  localparam logic [IdxW-1:0]  LastInit = IdxW'(NUM_REQ - 1);

  arb_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [NUM_REQ-1:0]       mask_q, mask_d;
  logic [IdxW-1:0]          last_q, last_d;
  logic [HoldW-1:0]         hold_q, hold_d;
  logic                     timeout_q, timeout_d;
  logic [nX-1:0]            vga_x_q, vga_x_d;
  logic [nY-1:0]            vga_y_q, vga_y_d;
  logic [COLOR_DEPTH-1:0]   vga_color_q, vga_color_d;
  logic                     vga_write_q, vga_write_d;

  logic [NUM_REQ-1:0]       eligible;
  logic [NUM_REQ-1:0]       pick_oh;
  logic                     pick_valid;
  logic [IdxW-1:0]          pick_idx;
  logic                     owner_req;

  logic                     pix_hit;
  logic [nX-1:0]            pix_x;
  logic [nY-1:0]            pix_y;
  logic [COLOR_DEPTH-1:0]   pix_color;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign eligible  = req & ~mask_q;
  assign owner_req = |(req & gnt_q);

  rr_picker #(
    .NumReq (NUM_REQ)
  ) u_rr_picker (
    .eligible_i (eligible),
    .last_i     (last_q),
    .winner_o   (pick_oh),
    .valid_o    (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_oh[k]) begin
        pick_idx = IdxW'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    // A masked requester becomes eligible again once it lets go of req.
    mask_d    = mask_q & req;

    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (pick_valid) begin
          gnt_d   = pick_oh;
          last_d  = pick_idx;
          hold_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          gnt_d   = '0;
          state_d = StIdle;
        end else if (hold_q == HoldMax) begin
          gnt_d     = '0;
          mask_d    = mask_d | gnt_q;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------------
  // The grant is one-hot, so at most one requester can hit. The owner's wr is
  // honoured for as long as its grant bit is set, regardless of req.
  always_comb begin
    pix_hit   = 1'b0;
    pix_x     = '0;
    pix_y     = '0;
    pix_color = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k] && wr[k]) begin
        pix_hit   = 1'b1;
        pix_x     = x_in[k*nX +: nX];
        pix_y     = y_in[k*nY +: nY];
        pix_color = color_in[k*COLOR_DEPTH +: COLOR_DEPTH];
      end
    end
  end

  // Clipped pixels leave the previous coordinate and colour on the bus.
  always_comb begin
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    vga_write_d = 1'b0;
    if (pix_hit && on_screen(pix_x, pix_y)) begin
      vga_x_d     = pix_x;
      vga_y_d     = pix_y;
      vga_color_d = pix_color;
      vga_write_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      mask_q      <= '0;
      last_q      <= LastInit;
      hold_q      <= '0;
      timeout_q   <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mask_q      <= mask_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_write_q <= vga_write_d;
    end
  end

  assign gnt       = gnt_q;
  assign timeout   = timeout_q;
  assign VGA_x     = vga_x_q;
  assign VGA_y     = vga_y_q;
  assign VGA_color = vga_color_q;
  assign VGA_write = vga_write_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed self-checking bench for vga_write_arbiter.
module tb_vga_write_arbiter;

  localparam int unsigned NR       = 3;
  localparam int unsigned MAX_HOLD = 8192;

  logic          Clock;
  logic          Resetn;
  logic [NR-1:0] req;
  logic [NR-1:0] wr;
  logic [NR*10-1:0] x_in;
  logic [NR*9-1:0]  y_in;
  logic [NR*9-1:0]  color_in;
  logic [NR-1:0] gnt;
  logic [9:0]    VGA_x;
  logic [8:0]    VGA_y;
  logic [8:0]    VGA_color;
  logic          VGA_write;
  logic          timeout;

  int n_checks = 0;
  int n_pass   = 0;

  vga_write_arbiter #(
    .NUM_REQ  (NR),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .req       (req),
    .wr        (wr),
    .x_in      (x_in),
    .y_in      (y_in),
    .color_in  (color_in),
    .gnt       (gnt),
    .VGA_x     (VGA_x),
    .VGA_y     (VGA_y),
    .VGA_color (VGA_color),
    .VGA_write (VGA_write),
    .timeout   (timeout)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_pix(input int k, input logic [9:0] x, input logic [8:0] y,
                         input logic [8:0] c);
    x_in[k*10 +: 10]   = x;
    y_in[k*9 +: 9]     = y;
    color_in[k*9 +: 9] = c;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    req    = '0;
    wr     = '0;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  task automatic test_reset();
    x_in = '0; y_in = '0; color_in = '0;
    do_reset();
    n_checks++; if (gnt !== 3'b000) $display("FAIL reset_gnt: got %b want 000", gnt); else n_pass++;
    n_checks++; if (VGA_write !== 1'b0) $display("FAIL reset_write: got %b want 0", VGA_write); else n_pass++;
    n_checks++; if (VGA_x !== 10'd0) $display("FAIL reset_x: got %0d want 0", VGA_x); else n_pass++;
    n_checks++; if (VGA_y !== 9'd0) $display("FAIL reset_y: got %0d want 0", VGA_y); else n_pass++;
    n_checks++; if (VGA_color !== 9'd0) $display("FAIL reset_color: got %h want 0", VGA_color); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else n_pass++;
  endtask

  task automatic test_stream();
    logic [9:0] ex;
    logic [8:0] ey;
    logic [8:0] ec;
    req = 3'b001;
    tick();
    n_checks++; if (gnt !== 3'b001) $display("FAIL stream_grant: got %b want 001", gnt); else n_pass++;
    for (int i = 0; i < 3600; i++) begin
      ex = 10'(100 + i % 60);
      ey = 9'(10 + i / 60);
      ec = 9'(i);
      wr = 3'b001;
      set_pix(0, ex, ey, ec);
      tick();
      n_checks++;
      if ({VGA_write, VGA_x, VGA_y, VGA_color} !== {1'b1, ex, ey, ec})
        $display("FAIL stream_pixel %0d: got w=%b x=%0d y=%0d c=%h want w=1 x=%0d y=%0d c=%h",
                 i, VGA_write, VGA_x, VGA_y, VGA_color, ex, ey, ec);
      else n_pass++;
    end
    wr = 3'b000;
    tick();
    n_checks++;
    if ({VGA_write, VGA_x, VGA_y} !== {1'b0, 10'd159, 9'd69})
      $display("FAIL stream_end: got w=%b x=%0d y=%0d want w=0 x=159 y=69", VGA_write, VGA_x, VGA_y);
    else n_pass++;
    req = 3'b000;
    tick();
    n_checks++; if (gnt !== 3'b000) $display("FAIL stream_release: got %b want 000", gnt); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int owner;
    logic [2:0] exp_g;
    logic [9:0] ex;
    do_reset();
    req = 3'b111;
    tick();
    for (int r = 0; r < 4; r++) begin
      owner = r % 3;
      exp_g = 3'b001 << owner;
      n_checks++;
      if (gnt !== exp_g) $display("FAIL rr_grant round %0d: got %b want %b", r, gnt, exp_g);
      else n_pass++;
      for (int p = 0; p < 4; p++) begin
        ex = 10'(200 + r * 4 + p);
        wr = exp_g;
        set_pix(owner, ex, 9'd20, 9'(owner));
        tick();
        n_checks++;
        if ({VGA_write, VGA_x} !== {1'b1, ex})
          $display("FAIL rr_pixel round %0d: got w=%b x=%0d want w=1 x=%0d", r, VGA_write, VGA_x, ex);
        else n_pass++;
      end
      wr = 3'b000;
      req[owner] = 1'b0;
      tick();
      n_checks++;
      if (gnt !== 3'b000) $display("FAIL rr_idle_gap round %0d: got %b want 000", r, gnt);
      else n_pass++;
      tick();
      req[owner] = 1'b1;
    end
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_ignore_wr();
    do_reset();
    req = 3'b100;
    tick();
    n_checks++; if (gnt !== 3'b100) $display("FAIL ign_grant: got %b want 100", gnt); else n_pass++;
    set_pix(1, 10'd5, 9'd5, 9'h001);
    set_pix(2, 10'd300, 9'd200, 9'h1AB);
    wr = 3'b110;
    tick();
    n_checks++;
    if ({VGA_write, VGA_x, VGA_y, VGA_color} !== {1'b1, 10'd300, 9'd200, 9'h1AB})
      $display("FAIL ign_owner_pixel: got w=%b x=%0d y=%0d c=%h want w=1 x=300 y=200 c=1ab",
               VGA_write, VGA_x, VGA_y, VGA_color);
    else n_pass++;
    wr = 3'b010;
    tick();
    n_checks++;
    if ({VGA_write, VGA_x} !== {1'b0, 10'd300})
      $display("FAIL ign_foreign_wr: got w=%b x=%0d want w=0 x=300", VGA_write, VGA_x);
    else n_pass++;
    wr = 3'b000;
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_clip();
    do_reset();
    req = 3'b001;
    tick();
    wr = 3'b001;
    set_pix(0, 10'd50, 9'd60, 9'h055);
    tick();
    n_checks++;
    if ({VGA_write, VGA_x, VGA_y, VGA_color} !== {1'b1, 10'd50, 9'd60, 9'h055})
      $display("FAIL clip_first: got w=%b x=%0d y=%0d c=%h want w=1 x=50 y=60 c=055",
               VGA_write, VGA_x, VGA_y, VGA_color);
    else n_pass++;
    set_pix(0, 10'd640, 9'd10, 9'h1FF);
    tick();
    n_checks++;
    if ({VGA_write, VGA_x, VGA_y, VGA_color} !== {1'b0, 10'd50, 9'd60, 9'h055})
      $display("FAIL clip_x640: got w=%b x=%0d y=%0d c=%h want w=0 x=50 y=60 c=055",
               VGA_write, VGA_x, VGA_y, VGA_color);
    else n_pass++;
    set_pix(0, 10'd10, 9'd480, 9'h1EE);
    tick();
    n_checks++;
    if ({VGA_write, VGA_x, VGA_y, VGA_color} !== {1'b0, 10'd50, 9'd60, 9'h055})
      $display("FAIL clip_y480: got w=%b x=%0d y=%0d c=%h want w=0 x=50 y=60 c=055",
               VGA_write, VGA_x, VGA_y, VGA_color);
    else n_pass++;
    set_pix(0, 10'd639, 9'd479, 9'h0AA);
    tick();
    n_checks++;
    if ({VGA_write, VGA_x, VGA_y, VGA_color} !== {1'b1, 10'd639, 9'd479, 9'h0AA})
      $display("FAIL clip_corner: got w=%b x=%0d y=%0d c=%h want w=1 x=639 y=479 c=0aa",
               VGA_write, VGA_x, VGA_y, VGA_color);
    else n_pass++;
    wr = 3'b000;
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    req = 3'b010;
    tick();
    n_checks++; if (gnt !== 3'b010) $display("FAIL to_grant: got %b want 010", gnt); else n_pass++;
    req = 3'b011;
    bad = 0;
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      if (gnt !== 3'b010 || timeout !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL to_hold_steady: got %0d bad cycles want 0", bad); else n_pass++;
    tick();
    n_checks++;
    if ({gnt, timeout} !== {3'b000, 1'b1})
      $display("FAIL to_release: got gnt=%b timeout=%b want gnt=000 timeout=1", gnt, timeout);
    else n_pass++;
    tick();
    n_checks++;
    if ({gnt, timeout} !== {3'b001, 1'b0})
      $display("FAIL to_next_owner: got gnt=%b timeout=%b want gnt=001 timeout=0", gnt, timeout);
    else n_pass++;
    req = 3'b010;
    tick();
    tick();
    tick();
    n_checks++; if (gnt !== 3'b000) $display("FAIL to_masked: got %b want 000", gnt); else n_pass++;
    req = 3'b000;
    tick();
    req = 3'b010;
    tick();
    n_checks++; if (gnt !== 3'b010) $display("FAIL to_regrant: got %b want 010", gnt); else n_pass++;
    req = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 3'b001;
    tick();
    wr = 3'b001;
    set_pix(0, 10'd123, 9'd45, 9'h155);
    tick();
    set_pix(0, 10'd124, 9'd46, 9'h156);
    Resetn = 1'b0;
    tick();
    n_checks++;
    if ({gnt, VGA_write, VGA_x, VGA_y, VGA_color, timeout} !== 33'd0)
      $display("FAIL mid_reset_outputs: got gnt=%b w=%b x=%0d y=%0d c=%h to=%b want all 0",
               gnt, VGA_write, VGA_x, VGA_y, VGA_color, timeout);
    else n_pass++;
    Resetn = 1'b1;
    wr = 3'b000;
    req = 3'b111;
    tick();
    n_checks++; if (gnt !== 3'b001) $display("FAIL mid_reset_first_grant: got %b want 001", gnt); else n_pass++;
    req = 3'b000;
    tick();
    tick();
  endtask

  initial begin
    Resetn = 1'b0;
    req = '0;
    wr = '0;
    test_reset();
    test_stream();
    test_round_robin();
    test_ignore_wr();
    test_clip();
    test_timeout();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
